control_sequencer: RTL and testbench

- Moore/Mealy microcode-free FSM that drives the control inputs of the existing `Calculation_and_Register` datapath: `arload`, `pcload`, `pcinc`, `pcbus`, `drload`, `drbus`, `membus`, `alusel`, `ac_load`, `ac_inc`, `irload`.
- It also drives the memory strobes and consumes the `Instr` opcode returned by the datapath.
- It implements the fetch/decode/execute cycle of the simple CPU, with a memory ready handshake and a timeout fault.

---
 rtl/control_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the Calculation_and_Register datapath.
// Outputs decode from state; memory handshake and timeout in next-state logic.
module control_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       Instr,
   input  logic             z,
   input  logic             mem_ready,
   output logic             arload,
   output logic             pcload,
   output logic             pcinc,
   output logic             pcbus,
   output logic             drload,
   output logic             drbus,
   output logic             membus,
   output logic             irload,
   output logic             ac_load,
   output logic             ac_inc,
   output logic             acbus,
   output logic [2:0]       alusel,
   output logic             rd,
   output logic             wr,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_F1, S_F2, S_F3, S_DEC, S_A1,
      S_R1, S_X1, S_W1, S_HALT, S_FAULT
   } state_e;

   localparam logic [7:0] TO_M1 = 8'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q;
   logic             retire;
   logic             mem_st;

   assign mem_st = (state_q == S_F2) || (state_q == S_R1) ||
                   (state_q == S_W1);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      wait_d  = '0;
      retire  = 1'b0;
      unique case (state_q)
         S_F1: state_d = S_F2;
         S_F2: if (mem_ready) state_d = S_F3;
         S_F3: state_d = S_DEC;
         S_DEC: begin
            op_d = Instr;
            if (Instr == 4'hF) begin
               state_d = S_HALT;
            end else if (Instr inside {[4'h1:4'h7]}) begin
               state_d = S_A1;
            end else begin
               state_d = S_F1;
               retire  = 1'b1;
            end
         end
         S_A1: state_d = (op_q == 4'h2) ? S_W1 : S_R1;
         S_R1: if (mem_ready) state_d = S_X1;
         S_X1: begin
            state_d = S_F1;
            retire  = 1'b1;
         end
         S_W1: if (mem_ready) begin
            state_d = S_F1;
            retire  = 1'b1;
         end
         default: state_d = state_q;
      endcase
      // A stalled memory access either keeps counting or gives up.
      if (mem_st && !mem_ready) begin
         if (wait_q == TO_M1) state_d = S_FAULT;
         else                 wait_d  = wait_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_F1;
         op_q    <= '0;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wait_q  <= wait_d;
         if (retire) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      arload  = 1'b0;
      pcload  = 1'b0;
      pcinc   = 1'b0;
      pcbus   = 1'b0;
      drload  = 1'b0;
      drbus   = 1'b0;
      membus  = 1'b0;
      irload  = 1'b0;
      ac_load = 1'b0;
      ac_inc  = 1'b0;
      acbus   = 1'b0;
      alusel  = 3'b000;
      rd      = 1'b0;
      wr      = 1'b0;
      halted  = 1'b0;
      fault   = 1'b0;
      if (!rst) begin
         unique case (state_q)
            S_F1: begin
               pcbus  = 1'b1;
               arload = 1'b1;
            end
            S_F2: begin
               rd     = 1'b1;
               membus = 1'b1;
               drload = mem_ready;
               pcinc  = mem_ready;
            end
            S_F3: begin
               drbus  = 1'b1;
               irload = 1'b1;
            end
            S_DEC: begin
               case (Instr)
                  4'h8: begin
                     ac_load = 1'b1;
                     alusel  = 3'b101;
                  end
                  4'h9: ac_inc = 1'b1;
                  4'hA: begin
                     drbus  = 1'b1;
                     pcload = 1'b1;
                  end
                  4'hB: begin
                     drbus  = 1'b1;
                     pcload = z;
                  end
                  4'hC: begin
                     ac_load = 1'b1;
                     alusel  = 3'b111;
                  end
                  default: ;
               endcase
            end
            S_A1: begin
               drbus  = 1'b1;
               arload = 1'b1;
            end
            S_R1: begin
               rd     = 1'b1;
               membus = 1'b1;
               drload = mem_ready;
            end
            S_X1: begin
               drbus   = 1'b1;
               ac_load = 1'b1;
               case (op_q)
                  4'h1:    alusel = 3'b110;
                  4'h4:    alusel = 3'b001;
                  4'h5:    alusel = 3'b010;
                  4'h6:    alusel = 3'b011;
                  4'h7:    alusel = 3'b100;
                  default: alusel = 3'b000;
               endcase
            end
            S_W1: begin
               acbus = 1'b1;
               wr    = 1'b1;
            end
            S_HALT: halted = 1'b1;
            S_FAULT: begin
               halted = 1'b1;
               fault  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: per-cycle control vectors plus a datapath/memory model.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  Instr;
   logic        z;
   logic        mem_ready = 1'b0;
   logic        arload, pcload, pcinc, pcbus, drload, drbus;
   logic        membus, irload, ac_load, ac_inc, acbus;
   logic [2:0]  alusel;
   logic        rd, wr, halted, fault;
   logic [15:0] instr_count;

   control_sequencer #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .Instr(Instr), .z(z),
      .mem_ready(mem_ready),
      .arload(arload), .pcload(pcload), .pcinc(pcinc),
      .pcbus(pcbus), .drload(drload), .drbus(drbus),
      .membus(membus), .irload(irload), .ac_load(ac_load),
      .ac_inc(ac_inc), .acbus(acbus), .alusel(alusel),
      .rd(rd), .wr(wr), .halted(halted), .fault(fault),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   localparam logic [17:0] C_AR  = 18'd1 << 17;
   localparam logic [17:0] C_PCL = 18'd1 << 16;
   localparam logic [17:0] C_PCI = 18'd1 << 15;
   localparam logic [17:0] C_PCB = 18'd1 << 14;
   localparam logic [17:0] C_DRL = 18'd1 << 13;
   localparam logic [17:0] C_DRB = 18'd1 << 12;
   localparam logic [17:0] C_MB  = 18'd1 << 11;
   localparam logic [17:0] C_IRL = 18'd1 << 10;
   localparam logic [17:0] C_ACL = 18'd1 << 9;
   localparam logic [17:0] C_ACI = 18'd1 << 8;
   localparam logic [17:0] C_ACB = 18'd1 << 7;
   localparam logic [17:0] C_RD  = 18'd1 << 6;
   localparam logic [17:0] C_WR  = 18'd1 << 5;
   localparam logic [17:0] C_HLT = 18'd1 << 4;
   localparam logic [17:0] C_FLT = 18'd1 << 3;

   localparam logic [17:0] F1V = C_PCB | C_AR;
   localparam logic [17:0] F2V = C_RD | C_MB | C_DRL | C_PCI;
   localparam logic [17:0] F2W = C_RD | C_MB;
   localparam logic [17:0] F3V = C_DRB | C_IRL;
   localparam logic [17:0] A1V = C_DRB | C_AR;
   localparam logic [17:0] R1V = C_RD | C_MB | C_DRL;
   localparam logic [17:0] R1W = C_RD | C_MB;
   localparam logic [17:0] X1V = C_DRB | C_ACL;
   localparam logic [17:0] W1V = C_ACB | C_WR;
   localparam logic [17:0] HV  = C_HLT;
   localparam logic [17:0] FV  = C_HLT | C_FLT;
   localparam logic [17:0] NIL = 18'd0;

   logic [17:0] ctl;
   assign ctl = {arload, pcload, pcinc, pcbus, drload, drbus, membus,
                 irload, ac_load, ac_inc, acbus, rd, wr, halted, fault,
                 alusel};

   // datapath and memory model
   logic [15:0] mem [0:255];
   logic [11:0] pc, ar, fa;
   logic [15:0] dr, ir, acc, bus, alu;
   int          nwr, lat, rd_dly, wr_dly;
   logic        stall;

   assign Instr = ir[15:12];
   assign z     = (acc == 16'h0);

   always_comb begin
      bus = 16'h0;
      if (pcbus)       bus = {4'h0, pc};
      else if (drbus)  bus = dr;
      else if (membus) bus = mem[ar[7:0]];
      else if (acbus)  bus = acc;
   end

   always_comb begin
      alu = 16'h0;
      case (alusel)
         3'd0: alu = acc + bus;
         3'd1: alu = acc - bus;
         3'd2: alu = acc & bus;
         3'd3: alu = acc | bus;
         3'd4: alu = acc ^ bus;
         3'd5: alu = ~acc;
         3'd6: alu = bus;
         default: alu = 16'h0;
      endcase
   end

   always @(posedge clk) begin
      if (rst) begin
         pc <= '0; ar <= '0; fa <= '0;
         dr <= '0; ir <= '0; acc <= '0;
         nwr <= 0; lat <= 0;
      end else begin
         if (arload) ar <= bus[11:0];
         if (pcload) pc <= bus[11:0];
         else if (pcinc) pc <= pc + 12'd1;
         if (drload) dr <= bus;
         if (irload) ir <= bus;
         if (ac_load) acc <= alu;
         else if (ac_inc) acc <= acc + 16'd1;
         if (pcbus && arload) fa <= pc;
         if (wr && mem_ready) nwr <= nwr + 1;
         if ((rd || wr) && !mem_ready) lat <= lat + 1;
         else lat <= 0;
      end
   end

   always @(posedge clk) begin
      if (!rst && wr && mem_ready) mem[ar[7:0]] = acc;
   end

   always @(posedge clk) begin
      #2;
      mem_ready = !stall && ((rd && lat >= rd_dly) ||
                             (wr && lat >= wr_dly));
   end

   // scoreboard
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [17:0] exp_q [$];
   logic [17:0] e;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, want,
                  $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ctl", {14'h0, ctl}, {14'h0, e});
         chk("one_bus", 32'($countones({pcbus, drbus, membus, acbus}) > 1),
             32'd0);
         chk("rd_wr", {31'h0, rd & wr}, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [17:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   task automatic fetch(input logic [17:0] f2, input int waits);
      push(F1V, 1);
      push(F2W, waits);
      push(f2, 1);
      push(F3V, 1);
   endtask

   task automatic run_q();
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick();
      chk("drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      push(NIL, 1);
      tick();
      rst = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
   endtask

   initial begin
      rst    = 1'b1;
      stall  = 1'b0;
      rd_dly = 0;
      wr_dly = 0;
      clear_mem();
      tick();
      tick();

      // NOP then HALT
      mem[1] = 16'hF000;
      do_reset();
      fetch(F2V, 0);
      push(NIL, 1);
      run_q();
      chk("nop_cnt", {16'h0, instr_count}, 32'd1);
      fetch(F2V, 0);
      push(NIL, 1);
      push(HV, 20);
      run_q();
      chk("halt_cnt", {16'h0, instr_count}, 32'd1);
      chk("halt_fa", {20'h0, fa}, 32'h001);

      // LDAC 0x010 ; ADD 0x011
      clear_mem();
      mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'hF000;
      mem[16] = 16'h0002; mem[17] = 16'h0003;
      do_reset();
      fetch(F2V, 0); push(NIL, 1); push(A1V, 1); push(R1V, 1);
      push(X1V | 18'd6, 1);
      fetch(F2V, 0); push(NIL, 1); push(A1V, 1); push(R1V, 1);
      push(X1V | 18'd0, 1);
      fetch(F2V, 0); push(NIL, 1); push(HV, 2);
      run_q();
      chk("add_acc", {16'h0, acc}, 32'h0005);
      chk("add_cnt", {16'h0, instr_count}, 32'd2);

      // LDAC then STAC with a slow write
      clear_mem();
      mem[0] = 16'h1010; mem[1] = 16'h2020; mem[2] = 16'hF000;
      mem[16] = 16'h1234;
      wr_dly = 3;
      do_reset();
      fetch(F2V, 0); push(NIL, 1); push(A1V, 1); push(R1V, 1);
      push(X1V | 18'd6, 1);
      fetch(F2V, 0); push(NIL, 1); push(A1V, 1); push(W1V, 4);
      fetch(F2V, 0); push(NIL, 1); push(HV, 2);
      run_q();
      chk("st_nwr", nwr, 32'd1);
      chk("st_mem", {16'h0, mem[32]}, 32'h1234);
      chk("st_cnt", {16'h0, instr_count}, 32'd2);
      wr_dly = 0;

      // CLAC ; JMPZ taken
      clear_mem();
      mem[0] = 16'hC000; mem[1] = 16'hB020; mem[32] = 16'hF000;
      do_reset();
      fetch(F2V, 0); push(C_ACL | 18'd7, 1);
      fetch(F2V, 0); push(C_DRB | C_PCL, 1);
      fetch(F2V, 0); push(NIL, 1); push(HV, 1);
      run_q();
      chk("jz1_fa", {20'h0, fa}, 32'h020);
      chk("jz1_cnt", {16'h0, instr_count}, 32'd2);

      // LDAC nonzero ; JMPZ not taken
      clear_mem();
      mem[0] = 16'h1030; mem[1] = 16'hB020; mem[2] = 16'hF000;
      mem[48] = 16'h0007;
      do_reset();
      fetch(F2V, 0); push(NIL, 1); push(A1V, 1); push(R1V, 1);
      push(X1V | 18'd6, 1);
      fetch(F2V, 0); push(C_DRB, 1);
      fetch(F2V, 0); push(NIL, 1); push(HV, 1);
      run_q();
      chk("jz0_fa", {20'h0, fa}, 32'h002);
      chk("jz0_cnt", {16'h0, instr_count}, 32'd2);

      // reset in the middle of an R1 wait
      clear_mem();
      mem[0] = 16'h0000; mem[1] = 16'h1010; mem[16] = 16'h0005;
      rd_dly = 2;
      do_reset();
      fetch(F2V, 2); push(NIL, 1);
      fetch(F2V, 2); push(NIL, 1); push(A1V, 1); push(R1W, 1);
      run_q();
      chk("mid_pre", {16'h0, instr_count}, 32'd1);
      do_reset();
      chk("mid_cnt", {16'h0, instr_count}, 32'd0);
      push(F1V, 1);
      run_q();
      rd_dly = 0;

      // memory never answers the fetch
      stall = 1'b1;
      do_reset();
      push(F1V, 1); push(F2W, 8); push(FV, 5);
      run_q();
      chk("to_cnt", {16'h0, instr_count}, 32'd0);
      stall = 1'b0;
      do_reset();
      push(F1V, 1);
      run_q();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
